sdram_port_sched: RTL and testbench

- Schedules one toggle-handshake SDRAM port between two requesters: the Oric CPU/ULA byte bus (`ram_cs`/`ram_oe`/`ram_we` style) and a byte-stream loader (ioctl download or FDC buffer fill).
- Replaces ad-hoc edge detection in the top level with a single owned sequencer.
- Sits in the SDRAM clock domain, between the core and the `sdram` controller port.
- Gives the CPU strict priority. Loader writes use idle slots.

---
 rtl/oric_mem_pkg.sv | 28 ++
 rtl/cpu_access_detect.sv | 37 +++
 rtl/sdram_port_sched.sv | 155 +++++++++++++++
 tb/tb_sdram_port_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oric_mem_pkg.sv
// Shared types for the SDRAM port scheduler: FSM states, byte-lane codes and the request slot.
package oric_mem_pkg;

  localparam int SD_ADDR_W = 24;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_WAIT = 2'd1,
    DL_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] DS_LO   = 2'b01;
  localparam logic [1:0] DS_HI   = 2'b10;
  localparam logic [1:0] DS_WORD = 2'b11;

  typedef struct packed {
    logic [SD_ADDR_W-1:0] addr;
    logic [7:0]           data;
    logic                 we;
  } req_t;

  // Reads fetch the whole word; byte writes enable only the addressed lane.
  function automatic logic [1:0] req_lanes(input req_t r);
    if (!r.we) return DS_WORD;
    return r.addr[0] ? DS_HI : DS_LO;
  endfunction

endpackage

// File: rtl/cpu_access_detect.sv
// Turns the level-style CPU RAM strobes into a one-cycle access trigger (rising cs&oe,
// rising cs&we, or a new address under a held read); combinational on the current inputs.
module cpu_access_detect (
  input  logic        clk_sys,
  input  logic        res_n,
  input  logic        cpu_cs,
  input  logic        cpu_oe,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  output logic        trigger
);

  logic        rd;
  logic        wr;
  logic        rd_q;
  logic        wr_q;
  logic [15:0] addr_q;

  assign rd = cpu_cs & cpu_oe;
  assign wr = cpu_cs & cpu_we;

  // A held write never retriggers on address motion; a held read does, so streamed reads work.
  assign trigger = (rd & ~rd_q) | (wr & ~wr_q) | (rd & (cpu_addr != addr_q));

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      rd_q   <= rd;
      wr_q   <= wr;
      addr_q <= cpu_addr;
    end
  end

endmodule

// File: rtl/sdram_port_sched.sv
// Arbitrates one toggle-handshake SDRAM port: CPU accesses have strict priority, loader bytes
// fill idle slots; a request toggles sd_req on the edge after it is seen, dl_ready gates the loader.
module sdram_port_sched
  import oric_mem_pkg::*;
#(
  parameter int                ADDR_W   = SD_ADDR_W,
  parameter logic [ADDR_W-1:0] CPU_BASE = 24'h000000,
  parameter int                TIMEOUT  = 63
) (
  input  logic              clk_sys,
  input  logic              res_n,
  input  logic              cpu_cs,
  input  logic              cpu_oe,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_ready,
  output logic              sd_req,
  input  logic              sd_ack,
  output logic [ADDR_W-1:0] sd_a,
  output logic              sd_we,
  output logic [1:0]        sd_ds,
  output logic [15:0]       sd_d,
  input  logic [15:0]       sd_q,
  output logic              busy,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t           state;
  state_t           state_n;
  logic             trigger;
  logic             cpu_pend;
  logic             cpu_pend_n;
  logic             dl_pend;
  logic             dl_pend_n;
  req_t             cpu_slot;
  req_t             dl_slot;
  req_t             cpu_now;
  req_t             dl_now;
  req_t             cpu_sel;
  req_t             dl_sel;
  req_t             issue_req;
  logic             issue;
  logic             latch_rd;
  logic             err_n;
  logic             dl_ready_n;
  logic             dl_acc;
  logic             acked;
  logic             timed_out;
  logic [CNT_W-1:0] wait_cnt;

  cpu_access_detect u_detect (
    .clk_sys  (clk_sys),
    .res_n    (res_n),
    .cpu_cs   (cpu_cs),
    .cpu_oe   (cpu_oe),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .trigger  (trigger)
  );

  assign cpu_now   = '{addr: CPU_BASE + {{(ADDR_W-16){1'b0}}, cpu_addr},
                       data: cpu_din, we: cpu_cs & cpu_we};
  assign dl_now    = '{addr: dl_addr, data: dl_data, we: 1'b1};
  assign dl_acc    = dl_wr & dl_ready;
  // A request arriving while IDLE goes straight out instead of through its slot.
  assign cpu_sel   = trigger ? cpu_now : cpu_slot;
  assign dl_sel    = dl_acc ? dl_now : dl_slot;
  assign acked     = (sd_ack == sd_req);
  assign timed_out = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign busy      = (state != IDLE);

  always_comb begin
    state_n    = state;
    cpu_pend_n = cpu_pend | trigger;
    dl_pend_n  = dl_pend | dl_acc;
    issue      = 1'b0;
    issue_req  = cpu_sel;
    latch_rd   = 1'b0;
    err_n      = err;
    case (state)
      IDLE: begin
        if (cpu_pend | trigger) begin
          issue      = 1'b1;
          issue_req  = cpu_sel;
          cpu_pend_n = 1'b0;
          state_n    = CPU_WAIT;
        end else if (dl_pend | dl_acc) begin
          issue     = 1'b1;
          issue_req = dl_sel;
          dl_pend_n = 1'b0;
          state_n   = DL_WAIT;
        end
      end
      CPU_WAIT, DL_WAIT: begin
        if (acked) begin
          state_n  = IDLE;
          latch_rd = (state == CPU_WAIT) & ~sd_we;
        end else if (timed_out) begin
          // sd_req is left as is; the next issue re-aligns toggle parity with the controller.
          state_n = IDLE;
          err_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Registered one cycle early, so a trigger can still coincide with an accepted dl_wr.
    dl_ready_n = (state_n == IDLE) & ~cpu_pend_n & ~dl_pend_n;
  end

  always_ff @(posedge clk_sys or negedge res_n) begin
    if (!res_n) begin
      state    <= IDLE;
      cpu_pend <= 1'b0;
      dl_pend  <= 1'b0;
      cpu_slot <= '0;
      dl_slot  <= '0;
      sd_req   <= 1'b0;
      sd_a     <= '0;
      sd_we    <= 1'b0;
      sd_ds    <= DS_WORD;
      sd_d     <= '0;
      cpu_dout <= '0;
      dl_ready <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      cpu_pend <= cpu_pend_n;
      dl_pend  <= dl_pend_n;
      err      <= err_n;
      dl_ready <= dl_ready_n;
      if (trigger) cpu_slot <= cpu_now;
      if (dl_acc)  dl_slot  <= dl_now;
      if (issue) begin
        sd_req   <= ~sd_req;
        sd_a     <= issue_req.addr;
        sd_we    <= issue_req.we;
        sd_ds    <= req_lanes(issue_req);
        sd_d     <= {2{issue_req.data}};
        wait_cnt <= '0;
      end else if (busy && (wait_cnt != CNT_W'(TIMEOUT))) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (latch_rd) cpu_dout <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
    end
  end

endmodule

// File: tb/tb_sdram_port_sched.sv
// Scoreboarded bench: stimulus pushes expected transfers, a monitor checks each sd_req toggle and read-back byte.
module tb_sdram_port_sched;

  localparam int TMO = 63;

  logic        clk_sys = 1'b0;
  logic        res_n   = 1'b0;
  logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        dl_wr = 1'b0;
  logic [23:0] dl_addr = '0;
  logic [7:0]  dl_data = '0;
  logic        dl_ready;
  logic        sd_req;
  logic        sd_ack = 1'b0;
  logic [23:0] sd_a;
  logic        sd_we;
  logic [1:0]  sd_ds;
  logic [15:0] sd_d;
  logic [15:0] sd_q = '0;
  logic        busy;
  logic        err;

  sdram_port_sched #(.ADDR_W(24), .CPU_BASE(24'h000000), .TIMEOUT(TMO)) dut (
    .clk_sys(clk_sys), .res_n(res_n),
    .cpu_cs(cpu_cs), .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_ready(dl_ready),
    .sd_req(sd_req), .sd_ack(sd_ack), .sd_a(sd_a), .sd_we(sd_we), .sd_ds(sd_ds),
    .sd_d(sd_d), .sd_q(sd_q), .busy(busy), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // mode: 0 no timing check, 1 toggle seen at cycle t, 2 toggle seen two cycles after the last ack
  typedef struct {logic [23:0] a; logic we; logic [7:0] d; int mode; int t;} exp_t;
  typedef struct {int t; logic [7:0] v;} dexp_t;

  exp_t        exp_q[$];
  dexp_t       dout_q[$];
  exp_t        inflight;
  int          n_cmp = 0, n_bad = 0;
  int          cyc = 0, tog_cnt = 0, last_ack = -100, ack_delay = 2;
  logic [15:0] next_q = '0;
  logic        ctl_busy = 1'b0;
  logic        last_req = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic logic [1:0] lanes(input exp_t e);
    if (!e.we) return 2'b11;
    return e.a[0] ? 2'b10 : 2'b01;
  endfunction

  task automatic push_exp(input logic [23:0] a, input logic we, input logic [7:0] d,
                          input int mode, input int t);
    exp_q.push_back('{a, we, d, mode, t});
  endtask

  always @(posedge clk_sys) begin : mon
    exp_t  e;
    dexp_t dx;
    cyc = cyc + 1;
    #1;
    if (!res_n) begin
      last_req = sd_req;
    end else begin
      if (sd_req !== last_req) begin
        last_req = sd_req;
        tog_cnt++;
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_toggle: sd_a=%0h, no request was due", sd_a);
        end else begin
          e = exp_q.pop_front();
          inflight = e;
          chk("sd_a", 32'(sd_a), 32'(e.a));
          chk("sd_we", 32'(sd_we), 32'(e.we));
          chk("sd_ds", 32'(sd_ds), 32'(lanes(e)));
          if (e.we) chk("sd_d", 32'(sd_d), 32'({e.d, e.d}));
          if (e.mode == 1)      chk("toggle_cycle", cyc, e.t);
          else if (e.mode == 2) chk("toggle_after_ack", cyc - last_ack, 2);
        end
      end
      if (dout_q.size() > 0 && dout_q[0].t <= cyc) begin
        dx = dout_q.pop_front();
        chk("cpu_dout", 32'(cpu_dout), 32'(dx.v));
      end
    end
  end

  // Controller model: acks ack_delay cycles after seeing a toggle; negative delay never acks.
  always @(negedge clk_sys) begin : ctl
    int cnt;
    if (!res_n) begin
      sd_ack   = 1'b0;
      ctl_busy = 1'b0;
    end else if (!ctl_busy) begin
      if (sd_req !== sd_ack) begin
        ctl_busy = 1'b1;
        cnt = 0;
      end
    end else if (sd_req === sd_ack) begin
      ctl_busy = 1'b0;
    end else begin
      cnt++;
      if (ack_delay >= 0 && cnt >= ack_delay) begin
        sd_q     = next_q;
        sd_ack   = sd_req;
        ctl_busy = 1'b0;
        last_ack = cyc;
        if (!inflight.we)
          dout_q.push_back('{cyc + 1, inflight.a[0] ? next_q[15:8] : next_q[7:0]});
        next_q = 16'($urandom);
      end
    end
  end

  task automatic wait_idle(input string nm, input int bound);
    int n = 0;
    while (!(busy === 1'b0 && exp_q.size() == 0 && dout_q.size() == 0 && !ctl_busy) && n < bound) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: not idle within %0d cycles, %0d transfers still due", nm, bound, exp_q.size());
    end
  endtask

  task automatic cpu_access(input logic [15:0] a, input logic we, input logic [7:0] d);
    cpu_cs = 1'b1; cpu_oe = ~we; cpu_we = we; cpu_addr = a; cpu_din = d;
    push_exp({8'h00, a}, we, d, 1, cyc + 1);
    wait_idle("cpu_access", 100);
    cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic dl_send(input logic [23:0] a, input logic [7:0] d);
    int n = 0;
    while (dl_ready !== 1'b1 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    chk("dl_ready_wait", 32'(dl_ready), 32'd1);
    dl_wr = 1'b1; dl_addr = a; dl_data = d;
    push_exp(a, 1'b1, d, 1, cyc + 1);
    @(negedge clk_sys);
    dl_wr = 1'b0;
    chk("dl_ready_drop", 32'(dl_ready), 32'd0);
  endtask

  initial begin : stim
    int t0, t_iss, n;
    // Reset with inputs toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      cpu_cs = 1'($urandom); cpu_oe = 1'($urandom); cpu_we = 1'($urandom);
      cpu_addr = 16'($urandom); dl_wr = 1'($urandom); dl_addr = 24'($urandom);
      if (i == 2 || i == 5) begin
        chk("rst_sd_req", 32'(sd_req), 0);
        chk("rst_dl_ready", 32'(dl_ready), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_cpu_dout", 32'(cpu_dout), 0);
        chk("rst_sd_ds", 32'(sd_ds), 32'h3);
      end
    end
    @(negedge clk_sys);
    cpu_cs = 0; cpu_oe = 0; cpu_we = 0; cpu_addr = '0; dl_wr = 0; dl_addr = '0;
    @(negedge clk_sys);
    res_n = 1'b1;
    @(negedge clk_sys);
    chk("post_rst_dl_ready", 32'(dl_ready), 1);
    repeat (3) @(negedge clk_sys);
    chk("post_rst_sd_req", 32'(sd_req), 0);

    // CPU read at 1235, word AB12 -> high byte
    ack_delay = 4; next_q = 16'hAB12;
    cpu_access(16'h1235, 1'b0, 8'h00);
    chk("dout_hold", 32'(cpu_dout), 32'hAB);

    // CPU write 5A at 0400, address moves under a held write
    t0 = tog_cnt;
    cpu_cs = 1; cpu_we = 1; cpu_oe = 0; cpu_addr = 16'h0400; cpu_din = 8'h5A;
    push_exp(24'h000400, 1'b1, 8'h5A, 1, cyc + 1);
    repeat (2) @(negedge clk_sys);
    cpu_addr = 16'h0401;
    @(negedge clk_sys);
    cpu_addr = 16'h0402;
    wait_idle("write", 100);
    repeat (4) @(negedge clk_sys);
    chk("write_no_retrigger", tog_cnt - t0, 1);
    chk("dout_after_write", 32'(cpu_dout), 32'hAB);
    cpu_cs = 0; cpu_we = 0;
    @(negedge clk_sys);

    // Loader stream of three bytes, plus an illegal strobe while dl_ready is low
    ack_delay = 2; t0 = tog_cnt;
    dl_send(24'h010000, 8'h01);
    dl_wr = 1'b1; dl_addr = 24'h0ABCDE; dl_data = 8'hEE;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    dl_send(24'h010001, 8'h02);
    dl_send(24'h010002, 8'h03);
    wait_idle("loader", 100);
    repeat (3) @(negedge clk_sys);
    chk("loader_toggles", tog_cnt - t0, 3);
    chk("loader_ready_back", 32'(dl_ready), 1);

    // Collision: CPU read and loader byte together, then a second CPU read while waiting
    ack_delay = 4;
    chk("collide_ready", 32'(dl_ready), 1);
    cpu_cs = 1; cpu_oe = 1; cpu_addr = 16'h2000;
    dl_wr = 1; dl_addr = 24'h020000; dl_data = 8'h77;
    push_exp(24'h002000, 1'b0, 8'h00, 1, cyc + 1);
    push_exp(24'h002003, 1'b0, 8'h00, 2, 0);
    push_exp(24'h020000, 1'b1, 8'h77, 2, 0);
    @(negedge clk_sys);
    dl_wr = 0;
    @(negedge clk_sys);
    cpu_addr = 16'h2003;
    wait_idle("collision", 200);
    cpu_cs = 0; cpu_oe = 0;
    @(negedge clk_sys);

    // Timeout with a controller that never answers
    ack_delay = -1;
    cpu_cs = 1; cpu_oe = 1; cpu_addr = 16'h3000;
    t_iss = cyc + 1;
    push_exp(24'h003000, 1'b0, 8'h00, 1, t_iss);
    n = 0;
    while (cyc < t_iss + TMO - 1 && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    chk("tmo_err_before", 32'(err), 0);
    chk("tmo_busy_before", 32'(busy), 1);
    @(negedge clk_sys);
    chk("tmo_err", 32'(err), 1);
    chk("tmo_busy_after", 32'(busy), 0);
    chk("tmo_dl_ready", 32'(dl_ready), 1);
    cpu_cs = 0; cpu_oe = 0;
    @(negedge clk_sys);
    t0 = tog_cnt;
    cpu_cs = 1; cpu_oe = 1; cpu_addr = 16'h3001;
    push_exp(24'h003001, 1'b0, 8'h00, 1, cyc + 1);
    wait_idle("post_timeout", 50);
    chk("post_tmo_toggle", tog_cnt - t0, 1);
    cpu_cs = 0; cpu_oe = 0;
    @(negedge clk_sys);

    // Randomised mix of complete CPU accesses and loader bursts
    for (int k = 0; k < 40; k++) begin
      ack_delay = int'($urandom_range(1, 6));
      case ($urandom_range(0, 2))
        0: cpu_access(16'($urandom), 1'b0, 8'h00);
        1: cpu_access(16'($urandom), 1'b1, 8'($urandom));
        default: begin
          logic [23:0] base;
          base = 24'($urandom);
          for (int j = 0; j < int'($urandom_range(1, 4)); j++)
            dl_send(base + 24'(j), 8'($urandom));
          wait_idle("rand_loader", 100);
          @(negedge clk_sys);
        end
      endcase
    end

    chk("err_sticky", 32'(err), 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, required under 50000", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
